// File: rtl/sar_adc_ctrl_if.sv
// Pin bundle between the SAR controller and its start pad, comparator/DAC macro and result pads.
interface sar_adc_ctrl_if #(parameter int SIZE = 8);
   logic            start;
   logic            cmp;
   logic            sample;
   logic [SIZE-1:0] dac_code;
   logic [SIZE-1:0] data;
   logic            done;
   logic            busy;

   modport master (output start, cmp, input sample, dac_code, data, done, busy);
   modport slave  (input start, cmp, output sample, dac_code, data, done, busy);
endinterface

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: sample/hold then MSB-first binary search on the capacitive DAC.
// Define SAR_CONT_EN for back-to-back conversions while start is held; default is one-shot.
module sar_adc_ctrl #(
   parameter int SIZE          = 8,
   parameter int SAMPLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rstn,
   sar_adc_ctrl_if.slave    bus
);

   localparam int BW  = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

   state_t          state, state_n;
   logic            sample_q, sample_n;
   logic [SIZE-1:0] dac_q, dac_n;
   logic [SIZE-1:0] data_q, data_n;
   logic            done_q, done_n;
   logic            busy_q, busy_n;
   logic [BW-1:0]   bit_idx, bit_n;
   logic [SCW-1:0]  scnt, scnt_n;

   logic [SIZE-1:0] trial;
   logic [SIZE-1:0] code;
   logic            go;

   assign bus.sample   = sample_q;
   assign bus.dac_code = dac_q;
   assign bus.data     = data_q;
   assign bus.done     = done_q;
   assign bus.busy     = busy_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         sample_q <= 1'b0;
         dac_q    <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         bit_idx  <= '0;
         scnt     <= '0;
      end else begin
         state    <= state_n;
         sample_q <= sample_n;
         dac_q    <= dac_n;
         data_q   <= data_n;
         done_q   <= done_n;
         busy_q   <= busy_n;
         bit_idx  <= bit_n;
         scnt     <= scnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      sample_n = sample_q;
      dac_n    = dac_q;
      data_n   = data_q;
      done_n   = done_q;
      busy_n   = busy_q;
      bit_n    = bit_idx;
      scnt_n   = scnt;
      go       = 1'b0;
      trial    = {{(SIZE-1){1'b0}}, 1'b1} << bit_idx;
      // current trial bit is kept when the comparator says vin >= dac_code
      code     = bus.cmp ? dac_q : (dac_q & ~trial);

      case (state)
         IDLE: go = bus.start;
         SAMPLE, CONV: begin
            if (!bus.start) begin
               state_n  = IDLE;
               sample_n = 1'b0;
               dac_n    = '0;
               busy_n   = 1'b0;
               done_n   = 1'b0;
            end else if (state == SAMPLE) begin
               if (scnt == SCW'(SAMPLE_CYCLES - 1)) begin
                  state_n  = CONV;
                  sample_n = 1'b0;
                  dac_n    = {1'b1, {(SIZE-1){1'b0}}};
               end else begin
                  scnt_n = scnt + SCW'(1);
               end
            end else if (bit_idx == '0) begin
               state_n = DONE;
               dac_n   = code;
               data_n  = code;
               done_n  = 1'b1;
               busy_n  = 1'b0;
            end else begin
               dac_n = code | (trial >> 1);
               bit_n = bit_idx - BW'(1);
            end
         end
         DONE: begin
`ifdef SAR_CONT_EN
            done_n = 1'b0;
            go     = bus.start;
            if (!bus.start) begin
               state_n = IDLE;
               dac_n   = '0;
            end
`else
            if (!bus.start) begin
               state_n = IDLE;
               done_n  = 1'b0;
               dac_n   = '0;
            end
`endif
         end
         default: state_n = IDLE;
      endcase

      if (go) begin
         state_n  = SAMPLE;
         sample_n = 1'b1;
         busy_n   = 1'b1;
         done_n   = 1'b0;
         dac_n    = '0;
         bit_n    = BW'(SIZE - 1);
         scnt_n   = '0;
      end
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl; comparator modelled as cmp = (vin >= dac_code).
module tb_sar_adc_ctrl;

   logic       clk;
   logic       rstn;
   logic [7:0] vin;
   int         n_cmp;
   int         n_err;

   sar_adc_ctrl_if #(.SIZE(8)) bus ();

   sar_adc_ctrl #(.SIZE(8), .SAMPLE_CYCLES(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   assign bus.cmp = (vin >= bus.dac_code);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end of test");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full conversion from IDLE: latency and result, then release start.
   task automatic do_conv(input logic [7:0] v, input string tag);
      int n;
      vin       = v;
      bus.start = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         chk({tag, "_excl"}, 32'(bus.busy & bus.done), 32'd0);
      end while (!bus.done && n < 30);
      chk({tag, "_lat"}, 32'(n - 1), 32'd10);
      chk({tag, "_data"}, 32'(bus.data), 32'(v));
      bus.start = 1'b0;
      tick();
      chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
   endtask

   logic [7:0] seq [8];
   logic [7:0] exp_dac;
   int         n;

   initial begin
      n_cmp = 0;
      n_err = 0;
      seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      rstn      = 1'b0;
      bus.start = 1'b0;
      vin       = 8'h00;
      #12;
      chk("rst_sample", 32'(bus.sample), 32'd0);
      chk("rst_dac",    32'(bus.dac_code), 32'd0);
      chk("rst_data",   32'(bus.data), 32'd0);
      chk("rst_done",   32'(bus.done), 32'd0);
      chk("rst_busy",   32'(bus.busy), 32'd0);
      rstn = 1'b1;
      tick();

      // 1: vin A5, cycle-by-cycle trace of sample / dac_code / done / busy
      vin       = 8'hA5;
      bus.start = 1'b1;
      for (int t = 1; t <= 11; t++) begin
         tick();
         exp_dac = (t <= 2) ? 8'h00 : (t <= 10) ? seq[t-3] : 8'hA5;
         chk("t1_sample", 32'(bus.sample), 32'(t <= 2));
         chk("t1_dac",    32'(bus.dac_code), 32'(exp_dac));
         chk("t1_done",   32'(bus.done), 32'(t == 11));
         chk("t1_busy",   32'(bus.busy), 32'(t <= 10));
      end
      chk("t1_data", 32'(bus.data), 32'hA5);

`ifndef SAR_CONT_EN
      // 5: one-shot holds done while start stays high, no new sampling
      for (int t = 0; t < 5; t++) begin
         tick();
         chk("t5_hold_done",   32'(bus.done), 32'd1);
         chk("t5_hold_sample", 32'(bus.sample), 32'd0);
         chk("t5_hold_busy",   32'(bus.busy), 32'd0);
      end
      bus.start = 1'b0;
      tick();
      chk("t5_drop_done", 32'(bus.done), 32'd0);
      chk("t5_keep_data", 32'(bus.data), 32'hA5);
      do_conv(8'h5A, "t5_restart");
`else
      tick();
      chk("t6_pulse", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      tick();
`endif

      // 2: extremes
      do_conv(8'h00, "t2_zero");
      do_conv(8'hFF, "t2_full");
      do_conv(8'hA5, "t3_prep");

      // 3: abort in 5th CONV cycle
      vin       = 8'h3C;
      bus.start = 1'b1;
      for (int t = 0; t < 7; t++) tick();
      bus.start = 1'b0;
      tick();
      chk("t3_busy",   32'(bus.busy), 32'd0);
      chk("t3_sample", 32'(bus.sample), 32'd0);
      chk("t3_dac",    32'(bus.dac_code), 32'd0);
      chk("t3_data",   32'(bus.data), 32'hA5);
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("t3_nodone", 32'(bus.done), 32'd0);
      end

      // 4: async reset mid-CONV, between edges
      vin       = 8'h3C;
      bus.start = 1'b1;
      for (int t = 0; t < 5; t++) tick();
      chk("t4_busy_pre", 32'(bus.busy), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("t4_busy", 32'(bus.busy), 32'd0);
      chk("t4_dac",  32'(bus.dac_code), 32'd0);
      chk("t4_data", 32'(bus.data), 32'd0);
      chk("t4_done", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      #1 rstn = 1'b1;
      tick();
      do_conv(8'h3C, "t4_after");

`ifdef SAR_CONT_EN
      // 6: continuous back-to-back conversions
      vin       = 8'h12;
      bus.start = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!bus.done && n < 30);
      chk("t6_lat0",  32'(n - 1), 32'd10);
      chk("t6_data0", 32'(bus.data), 32'h12);
      vin = 8'h34;
      n = 0;
      do begin
         tick();
         n++;
         if (n == 1) begin
            chk("t6_pulse_w", 32'(bus.done), 32'd0);
            chk("t6_resample", 32'(bus.sample), 32'd1);
            chk("t6_hold_data", 32'(bus.data), 32'h12);
         end
      end while (!bus.done && n < 30);
      chk("t6_period", 32'(n), 32'd11);
      chk("t6_data1",  32'(bus.data), 32'h34);
      bus.start = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
